i2c_arbiter: RTL
================

Name: i2c_arbiter

Overview:
- Shares one i2c_master between NUM_REQ independent requesters using round-robin arbitration.
- Latches the winning request (7-bit address, data byte, rw), pulses the master's start, and waits for completion or timeout.
- Returns read data and error status to the granted requester.
- Sits between on-chip clients (sensor pollers, config loaders) and the single i2c_master that drives the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the granted-id encoding; must equal clog2(NUM_REQ).
- TIMEOUT_CLKS, 4096, clk cycles allowed in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester transaction request
- req_addr  in  7*NUM_REQ  packed 7-bit slave addresses; requester i at [7i+6:7i]
- req_data  in  8*NUM_REQ  packed write bytes; requester i at [8i+7:8i]
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_ready  out  NUM_REQ  one-hot single-cycle acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot single-cycle completion pulse
- rsp_data  out  8  read byte, valid with rsp_valid; 0x00 for writes and errors
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- m_addr  out  7  to i2c_master address_in
- m_data  out  8  to i2c_master data_in
- m_rw  out  1  to i2c_master rw
- m_start  out  1  to i2c_master start_send; one-cycle pulse
- m_done  in  1  one-cycle completion pulse from the master when it returns to IDLE
- m_rdata  in  8  master read register; sampled on m_done

Behaviour:
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0x00, rsp_err 0, busy 0, m_start 0, m_addr 0, m_data 0, m_rw 0, timer 0, last_grant NUM_REQ-1 (requester 0 has top priority first).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, no req_valid bit set: stay in IDLE.
- IDLE, any req_valid bit set:
  - Grant g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register g, m_addr, m_data and m_rw from requester g's slices.
  - Pulse req_ready[g] for one cycle (registered, same edge as the latch), then go to ISSUE.
- ISSUE: m_start = 1 for exactly this one cycle; clear timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On m_done: capture m_rdata if m_rw = 1, else capture 0x00; clear the error flag; go to RESP.
  - Else if TIMEOUT_CLKS != 0 and timer == TIMEOUT_CLKS-1: rsp_data 0x00, rsp_err 1; go to RESP.
  - If m_done and timeout occur in the same cycle, m_done wins and no error is flagged.
- RESP: rsp_valid[g] = 1 for one cycle with rsp_data and rsp_err; last_grant <= g; go to IDLE.
- Latency: request accepted at edge t; m_start high during cycle t+1; rsp_valid high in the cycle after the m_done cycle.
- Minimum gap between two m_start pulses: 3 cycles plus the master transaction time.
- m_addr, m_data and m_rw stay stable from the ISSUE cycle through RESP; they change only on a new grant.
- Requesters hold their slices stable while req_valid is high. Dropping req_valid before req_ready is legal and creates no commitment.
- m_done seen in IDLE, ISSUE or RESP is ignored.
- req_valid on the currently granted requester during WAIT is not accepted until the next IDLE.
- Fairness: a requester that remains valid is granted within NUM_REQ transactions.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately (asynchronous).
  - No rsp_valid is issued for the aborted transaction.
  - The master receives its own reset from the same net.

Decomposition:
- Shared package i2c_pkg:
  - arbiter state encoding (IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11)
  - I2C_ADDR_W = 7, I2C_DATA_W = 8
- One sub-module, rr_pick:
  - Combinational round-robin priority selector.
  - Inputs: req vector and last_grant.
  - Outputs: grant id and any_req.
  - Reusable by future multi-master bus controllers.

Test Plan:
- Single write: req_valid = 4'b0010, addr 0x50, data 0xA5, rw 0 → req_ready = 4'b0010 next edge; m_start pulse with m_addr 0x50, m_data 0xA5, m_rw 0; after m_done, rsp_valid = 4'b0010, rsp_data 0x00, rsp_err 0.
- Read: requester 3, addr 0x68, rw 1; model drives m_rdata 0x3C with m_done → rsp_valid = 4'b1000, rsp_data 0x3C.
- Round-robin: all four requesters held valid for 8 transactions from reset → grant order 0,1,2,3,0,1,2,3.
- Timeout: TIMEOUT_CLKS = 16, m_done never asserted → rsp_valid exactly 16 cycles after the m_start cycle's successor, with rsp_err 1 and rsp_data 0x00; next request proceeds normally.
- Collision: m_done asserted in the same cycle as timeout expiry → rsp_err 0 and m_rdata captured.
- Reset mid-WAIT: assert reset 5 cycles after m_start → busy, m_start and all rsp_valid bits go to 0 immediately, no response is issued; after release, requester 0 wins when all requesters are valid.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and widths for the i2c request arbiter
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    // Scan upward from the requester after the last winner, wrapping, and take the first set bit
    always_comb begin
        int   idx;
        logic found;
        grant = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[ID_W'(idx)]) begin
                grant = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin sharing of one i2c_master among several requesters
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_rw,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [I2C_DATA_W-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic [I2C_DATA_W-1:0]         m_data,
    output logic                          m_rw,
    output logic                          m_start,
    input  logic                          m_done,
    input  logic [I2C_DATA_W-1:0]         m_rdata
);

    localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    arb_state_t      state;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] last_grant;
    logic [TMR_W-1:0] timer;
    logic [ID_W-1:0] pick_id;
    logic            any_req;
    logic            timeout_hit;

    logic [I2C_ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [I2C_DATA_W-1:0] data_arr [NUM_REQ];

    // Unpack the flat per-requester buses so the winner can be selected by id
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        assign data_arr[i] = req_data[i*I2C_DATA_W +: I2C_DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_id),
        .any_req    (any_req)
    );

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // A zero limit disables the abort entirely
    assign timeout_hit = (TIMEOUT_CLKS != 0) && (timer == TMR_W'(TIMEOUT_CLKS - 1));

    assign busy = (state != IDLE);

    // Arbitration FSM: grant, kick the master, wait for done or timeout, answer the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            timer      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
            m_rw       <= 1'b0;
            m_start    <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_start   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick_id;
                        m_addr    <= addr_arr[pick_id];
                        m_data    <= data_arr[pick_id];
                        m_rw      <= req_rw[pick_id];
                        req_ready <= onehot(pick_id);
                        m_start   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (m_done) begin
                        rsp_data  <= m_rw ? m_rdata : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
